// File: rtl/font_pkg.sv
// Shared font-ROM constants: glyph geometry, character codes and text requester IDs.
// Glyph address layout is {char_code[6:0], row[3:0]}.
package font_pkg;

  localparam int FONT_ROWS   = 16;
  localparam int FONT_ADDR_W = 11;

  localparam logic [6:0] CHR_S          = 7'h53;
  localparam logic [6:0] CHR_C          = 7'h43;
  localparam logic [6:0] CHR_O          = 7'h4F;
  localparam logic [6:0] CHR_R          = 7'h52;
  localparam logic [6:0] CHR_E          = 7'h45;
  localparam logic [6:0] CHR_DIGIT_BASE = 7'h30;

  typedef enum logic [1:0] {
    REQ_SCORE_LBL = 2'd0,
    REQ_SCORE_DIG = 2'd1,
    REQ_LIVES     = 2'd2,
    REQ_LEVEL     = 2'd3
  } req_id_e;

  function automatic logic [FONT_ADDR_W-1:0] glyph_addr(input logic [6:0] chr,
                                                         input logic [3:0] row);
    return {chr, row};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr wins.
// Shared with the sprite-ROM arbiter, so it carries no state of its own.
module rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_hit;

  // cand_idx[gi] is the requester examined at priority offset gi from ptr
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                   : sum[IDX_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  assign any = |req;

  always_comb begin
    winner = '0;
    for (int o = N - 1; o >= 0; o--) begin
      if (cand_hit[o]) winner = cand_idx[o];
    end
    grant = '0;
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous font ROM port among text requesters.
// Tracks each read through the ROM latency and returns the glyph row tagged with its requester ID.
module font_rom_arbiter
  import font_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = FONT_ADDR_W,
  parameter  int DATA_W  = 8,
  parameter  int ROM_LAT = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_sync,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    winner;
  logic               any;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [ADDR_W-1:0]  win_addr;

  logic               pipe_valid_reg [ROM_LAT+1];
  logic [ID_W-1:0]    pipe_id_reg    [ROM_LAT+1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_reg),
    .grant  (pick_grant),
    .winner (winner),
    .any    (any)
  );

  // Grant is masked while reset is held so nothing appears consumed
  assign grant    = Reset_n ? pick_grant : '0;
  assign win_addr = addr_arr[winner];

  always_comb begin
    ptr_next = ptr_reg;
    if (frame_sync) begin
      ptr_next = '0;
    end else if (any) begin
      ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_reg  <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      ptr_reg <= ptr_next;
      rom_en  <= any;
      if (any) rom_addr <= win_addr;
    end
  end

  // Stage 0 lines up with rom_en; stage ROM_LAT lines up with rom_data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int s = 0; s <= ROM_LAT; s++) begin
        pipe_valid_reg[s] <= 1'b0;
        pipe_id_reg[s]    <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= any;
      pipe_id_reg[0]    <= winner;
      for (int s = 1; s <= ROM_LAT; s++) begin
        pipe_valid_reg[s] <= pipe_valid_reg[s-1];
        pipe_id_reg[s]    <= pipe_id_reg[s-1];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= pipe_valid_reg[ROM_LAT];
      if (pipe_valid_reg[ROM_LAT]) begin
        rsp_id   <= pipe_id_reg[ROM_LAT];
        rsp_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: ROM_LAT=1 and ROM_LAT=2 instances share stimulus,
// checked every cycle against a grant/response history model plus literal expectations.
module tb_font_rom_arbiter;
  import font_pkg::*;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_sync;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]  grant     [2];
  logic [AW-1:0] rom_addr  [2];
  logic          rom_en    [2];
  logic [DW-1:0] rom_data  [2];
  logic          rsp_valid [2];
  logic [1:0]    rsp_id    [2];
  logic [DW-1:0] rsp_data  [2];
  logic [DW-1:0] rom2_stage;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  font_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut_l1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_sync(frame_sync), .req(req), .req_addr(req_addr),
    .grant(grant[0]), .rom_addr(rom_addr[0]), .rom_en(rom_en[0]), .rom_data(rom_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0])
  );

  font_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u_dut_l2 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_sync(frame_sync), .req(req), .req_addr(req_addr),
    .grant(grant[1]), .rom_addr(rom_addr[1]), .rom_en(rom_en[1]), .rom_data(rom_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1])
  );

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return (a[7:0] ^ a[10:3]) + 8'h1D;
  endfunction

  // Synchronous ROM models with 1 and 2 cycles of read latency
  always @(posedge Clk) begin
    if (rom_en[0]) rom_data[0] <= rom_fn(rom_addr[0]);
    if (rom_en[1]) rom2_stage <= rom_fn(rom_addr[1]);
    rom_data[1] <= rom2_stage;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-cycle grant history, responses looked up 2+LAT cycles later
  int           cyc    = 0;
  int           m_ptr  = 0;
  logic         m_en   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  bit           h_v    [4096];
  int           h_id   [4096];
  logic [AW-1:0] h_addr [4096];
  int           m_w;
  int           m_idx;
  int           m_src;
  logic [N-1:0] m_gnt;
  bit           m_ev;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_grant_l%0d", k+1), 32'(grant[k]), 32'd0);
        check($sformatf("rst_rom_en_l%0d", k+1), 32'(rom_en[k]), 32'd0);
        check($sformatf("rst_rom_addr_l%0d", k+1), 32'(rom_addr[k]), 32'd0);
        check($sformatf("rst_rsp_valid_l%0d", k+1), 32'(rsp_valid[k]), 32'd0);
        check($sformatf("rst_rsp_id_l%0d", k+1), 32'(rsp_id[k]), 32'd0);
        check($sformatf("rst_rsp_data_l%0d", k+1), 32'(rsp_data[k]), 32'd0);
      end
      m_ptr  = 0;
      m_en   = 1'b0;
      m_addr = '0;
      for (int j = cyc - 8; j <= cyc; j++) if (j >= 0) h_v[j] = 1'b0;
    end else begin
      m_w = -1;
      for (int o = N - 1; o >= 0; o--) begin
        m_idx = (m_ptr + o) % N;
        if (req[m_idx]) m_w = m_idx;
      end
      m_gnt = '0;
      if (m_w >= 0) m_gnt[m_w] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("grant_l%0d", k+1), 32'(grant[k]), 32'(m_gnt));
        check($sformatf("rom_en_l%0d", k+1), 32'(rom_en[k]), 32'(m_en));
        check($sformatf("rom_addr_l%0d", k+1), 32'(rom_addr[k]), 32'(m_addr));
        m_src = cyc - 3 - k;
        m_ev  = (m_src >= 0) && h_v[m_src];
        check($sformatf("rsp_valid_l%0d", k+1), 32'(rsp_valid[k]), 32'(m_ev));
        if (m_ev) begin
          check($sformatf("rsp_id_l%0d", k+1), 32'(rsp_id[k]), 32'(h_id[m_src]));
          check($sformatf("rsp_data_l%0d", k+1), 32'(rsp_data[k]), 32'(rom_fn(h_addr[m_src])));
        end
      end
      h_v[cyc] = (m_w >= 0);
      if (m_w >= 0) begin
        h_id[cyc]   = m_w;
        h_addr[cyc] = req_addr[m_w*AW +: AW];
        m_en        = 1'b1;
        m_addr      = req_addr[m_w*AW +: AW];
        m_ptr       = (m_w + 1) % N;
      end else begin
        m_en = 1'b0;
      end
      if (frame_sync) m_ptr = 0;
    end
    cyc++;
  end

  task automatic nxt;
    @(posedge Clk);
    #1;
  endtask

  task automatic smp;
    @(negedge Clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  initial begin
    Reset_n    = 1'b0;
    frame_sync = 1'b0;
    req        = '0;
    req_addr   = '0;
    set_addr(0, 11'h530);
    set_addr(1, 11'h301);
    set_addr(2, 11'h530);
    set_addr(3, 11'h453);
    repeat (2) @(posedge Clk);
    smp;
    check("lit_reset_rom_en", 32'(rom_en[0]), 32'd0);
    check("lit_reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    nxt;
    Reset_n = 1'b1;

    // Single requester: lives counter reading 'h530
    req = 4'b0100;
    smp;
    check("lit_single_grant", 32'(grant[0]), 32'(4'b1 << int'(REQ_LIVES)));
    nxt;
    req = '0;
    smp;
    check("lit_single_rom_addr", 32'(rom_addr[0]), 32'h530);
    check("lit_single_rom_en", 32'(rom_en[0]), 32'd1);
    nxt; smp;
    check("lit_single_t2_valid", 32'(rsp_valid[0]), 32'd0);
    nxt; smp;
    check("lit_single_t3_valid", 32'(rsp_valid[0]), 32'd1);
    check("lit_single_t3_id", 32'(rsp_id[0]), 32'd2);
    check("lit_single_t3_data", 32'(rsp_data[0]), 32'hB3);
    check("lit_single_t3_valid_l2", 32'(rsp_valid[1]), 32'd0);
    nxt; smp;
    check("lit_single_t4_valid_l1", 32'(rsp_valid[0]), 32'd0);
    check("lit_single_t4_valid_l2", 32'(rsp_valid[1]), 32'd1);
    check("lit_single_t4_data_l2", 32'(rsp_data[1]), 32'hB3);
    nxt; nxt;

    // All four requesting continuously from reset
    Reset_n = 1'b0;
    nxt; nxt;
    Reset_n = 1'b1;
    set_addr(2, 11'h4F2);
    req = 4'hF;
    for (int k = 0; k < 12; k++) begin
      smp;
      check($sformatf("lit_rr_grant_%0d", k), 32'(grant[0]), 32'(4'b1 << (k % 4)));
      if (k >= 3) begin
        check($sformatf("lit_rr_rsp_valid_%0d", k), 32'(rsp_valid[0]), 32'd1);
        check($sformatf("lit_rr_rsp_id_%0d", k), 32'(rsp_id[0]), 32'((k - 3) % 4));
      end
      nxt;
    end
    req = '0;
    repeat (5) nxt;

    // Pointer at 2 with only 1 and 3 asking
    req = 4'b0010;
    smp;
    check("lit_p2_setup", 32'(grant[0]), 32'b0010);
    nxt;
    req = 4'b1010;
    smp;
    check("lit_p2_first", 32'(grant[0]), 32'b1000);
    nxt; smp;
    check("lit_p2_second", 32'(grant[0]), 32'b0010);
    nxt;

    // frame_sync while pointer is 3
    req = 4'b0100;
    smp;
    check("lit_fs_setup", 32'(grant[0]), 32'b0100);
    nxt;
    req        = 4'hF;
    frame_sync = 1'b1;
    smp;
    check("lit_fs_current", 32'(grant[1]), 32'b1000);
    nxt;
    frame_sync = 1'b0;
    smp;
    check("lit_fs_next", 32'(grant[1]), 32'b0001);
    nxt;
    req = '0;
    repeat (5) nxt;

    // Reset with two reads in flight
    req = 4'hF;
    smp; nxt; smp; nxt;
    Reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("lit_async_grant_l%0d", k+1), 32'(grant[k]), 32'd0);
      check($sformatf("lit_async_rom_en_l%0d", k+1), 32'(rom_en[k]), 32'd0);
      check($sformatf("lit_async_rom_addr_l%0d", k+1), 32'(rom_addr[k]), 32'd0);
      check($sformatf("lit_async_rsp_valid_l%0d", k+1), 32'(rsp_valid[k]), 32'd0);
    end
    req = '0;
    nxt; nxt;
    Reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp;
      check($sformatf("lit_post_rst_l1_%0d", k), 32'(rsp_valid[0]), 32'd0);
      check($sformatf("lit_post_rst_l2_%0d", k), 32'(rsp_valid[1]), 32'd0);
      nxt;
    end

    // Back-to-back grants to 0 and 1, checked on the ROM_LAT=2 instance
    req = 4'b0011;
    smp;
    check("lit_l2_grant0", 32'(grant[1]), 32'b0001);
    nxt; smp;
    check("lit_l2_grant1", 32'(grant[1]), 32'b0010);
    nxt;
    req = '0;
    smp;
    check("lit_l2_t2_valid", 32'(rsp_valid[1]), 32'd0);
    nxt; smp;
    check("lit_l2_t3_valid", 32'(rsp_valid[1]), 32'd0);
    nxt; smp;
    check("lit_l2_t4_valid", 32'(rsp_valid[1]), 32'd1);
    check("lit_l2_t4_id", 32'(rsp_id[1]), 32'd0);
    check("lit_l2_t4_data", 32'(rsp_data[1]), 32'hB3);
    nxt; smp;
    check("lit_l2_t5_valid", 32'(rsp_valid[1]), 32'd1);
    check("lit_l2_t5_id", 32'(rsp_id[1]), 32'd1);
    check("lit_l2_t5_data", 32'(rsp_data[1]), 32'h7E);
    nxt;
    repeat (4) nxt;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
